// File: rtl/pong_pkg.sv
// Shared playfield constants, FSM state encoding and small geometry helpers
// used by the collision detector and its sub-blocks.
package pong_pkg;

  localparam logic [5:0] GRID_MAX = 6'd63;
  localparam logic [5:0] LPAD_X   = 6'd1;
  localparam logic [5:0] RPAD_X   = 6'd62;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GOAL  = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_e;

  // True when pos lies within [top, top+height-1]; widened to 7 bits so a
  // paddle near the bottom edge does not wrap back to row 0.
  function automatic logic in_span(input logic [5:0] pos,
                                   input logic [5:0] top,
                                   input logic [6:0] height);
    logic [6:0] pos_w;
    logic [6:0] top_w;
    logic [6:0] bot_w;
    pos_w = {1'b0, pos};
    top_w = {1'b0, top};
    bot_w = top_w + height - 7'd1;
    return (pos_w >= top_w) && (pos_w <= bot_w);
  endfunction

  // Row of the ball relative to the paddle top, clamped to 3 bits.
  function automatic logic [2:0] sat_offset(input logic [5:0] pos,
                                            input logic [5:0] top);
    logic [5:0] diff;
    diff = pos - top;
    if (diff > 6'd7) begin
      return 3'd7;
    end else begin
      return diff[2:0];
    end
  endfunction

endpackage

// File: rtl/collision_cooldown.sv
// Per-class pulse suppression: after a trigger, reports busy for the next
// COOLDOWN frame ticks so the same collision is not reported twice.
module collision_cooldown #(
  parameter int COOLDOWN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic trigger,
  output logic busy
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic [CW-1:0] count_r;

  // Reload on a pulse, otherwise count down once per frame tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (trigger) begin
      count_r <= CW'(COOLDOWN);
    end else if (frame_tick && (count_r != '0)) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign busy = (count_r != '0);

endmodule

// File: rtl/collision_detector.sv
// Pong rules engine: per frame tick, detects wall and paddle strikes, scores
// goals, sequences serve/goal/game-over and reports everything as registered
// outputs one cycle after the frame tick.
module collision_detector
  import pong_pkg::*;
#(
  parameter int PAD_H       = 8,
  parameter int COOLDOWN    = 2,
  parameter int SERVE_DELAY = 30,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [5:0] bx,
  input  logic [5:0] by,
  input  logic       bx_dir,
  input  logic       by_dir,
  input  logic [5:0] lpad_y,
  input  logic [5:0] rpad_y,
  output logic       paddle_collision,
  output logic       ball_collision,
  output logic [2:0] hit_offset,
  output logic       serve,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int               SCW        = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [SCW-1:0]   SERVE_LOAD = SCW'(SERVE_DELAY);
  localparam logic [6:0]       PAD_SPAN   = 7'(PAD_H);
  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [5:0]       LHIT_X     = LPAD_X + 6'd1;
  localparam logic [5:0]       RHIT_X     = RPAD_X - 6'd1;

  pong_state_e     state_r, state_s;
  logic [SCW-1:0]  serve_cnt_r, serve_cnt_s;
  logic            paddle_collision_r, paddle_collision_s;
  logic            ball_collision_r, ball_collision_s;
  logic [2:0]      hit_offset_r, hit_offset_s;
  logic            serve_r, serve_s;
  logic [3:0]      score_l_r, score_l_s;
  logic [3:0]      score_r_r, score_r_s;
  logic            game_over_r, game_over_s;

  logic wall_geom_s, lover_s, rover_s, lhit_s, rhit_s, lgoal_s, rgoal_s;
  logic play_tick_s, paddle_fire_s, wall_fire_s;
  logic paddle_busy_s, wall_busy_s;

  // Geometry: a goal only counts when the ball misses the paddle's rows, so
  // paddle overlap wins over a goal by construction.
  assign wall_geom_s   = ((by == 6'd0) && !by_dir) || ((by == GRID_MAX) && by_dir);
  assign lover_s       = in_span(by, lpad_y, PAD_SPAN);
  assign rover_s       = in_span(by, rpad_y, PAD_SPAN);
  assign lhit_s        = (bx <= LHIT_X) && !bx_dir && lover_s;
  assign rhit_s        = (bx >= RHIT_X) && bx_dir && rover_s;
  assign lgoal_s       = (bx == 6'd0) && !bx_dir && !lover_s;
  assign rgoal_s       = (bx == GRID_MAX) && bx_dir && !rover_s;
  assign play_tick_s   = frame_tick && (state_r == ST_PLAY);
  assign paddle_fire_s = play_tick_s && (lhit_s || rhit_s) && !paddle_busy_s;
  assign wall_fire_s   = play_tick_s && wall_geom_s && !wall_busy_s;

  collision_cooldown #(.COOLDOWN(COOLDOWN)) u_paddle_cd (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .trigger    (paddle_fire_s),
    .busy       (paddle_busy_s)
  );

  collision_cooldown #(.COOLDOWN(COOLDOWN)) u_wall_cd (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .trigger    (wall_fire_s),
    .busy       (wall_busy_s)
  );

  // Next-state and next-output decode for the serve/play/goal/over sequence.
  always_comb begin
    state_s            = state_r;
    serve_cnt_s        = serve_cnt_r;
    paddle_collision_s = paddle_fire_s;
    ball_collision_s   = wall_fire_s;
    serve_s            = 1'b0;
    hit_offset_s       = hit_offset_r;
    score_l_s          = score_l_r;
    score_r_s          = score_r_r;
    game_over_s        = game_over_r;

    if (paddle_fire_s) begin
      hit_offset_s = lhit_s ? sat_offset(by, lpad_y) : sat_offset(by, rpad_y);
    end else begin
      hit_offset_s = hit_offset_r;
    end

    case (state_r)
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_r <= SCW'(1)) begin
            serve_s     = 1'b1;
            serve_cnt_s = '0;
            state_s     = ST_PLAY;
          end else begin
            serve_cnt_s = serve_cnt_r - SCW'(1);
          end
        end else begin
          state_s = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (frame_tick && lgoal_s) begin
          score_r_s = score_r_r + 4'd1;
          state_s   = ST_GOAL;
        end else if (frame_tick && rgoal_s) begin
          score_l_s = score_l_r + 4'd1;
          state_s   = ST_GOAL;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_GOAL: begin
        if ((score_l_r == WIN_VAL) || (score_r_r == WIN_VAL)) begin
          state_s     = ST_OVER;
          game_over_s = 1'b1;
        end else begin
          state_s     = ST_SERVE;
          serve_cnt_s = SERVE_LOAD;
        end
      end
      ST_OVER: begin
        state_s     = ST_OVER;
        game_over_s = 1'b1;
      end
      default: begin
        state_s     = ST_SERVE;
        serve_cnt_s = SERVE_LOAD;
      end
    endcase
  end

  // State and output registers; reset wins over any pending update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r            <= ST_SERVE;
      serve_cnt_r        <= SERVE_LOAD;
      paddle_collision_r <= 1'b0;
      ball_collision_r   <= 1'b0;
      hit_offset_r       <= 3'd0;
      serve_r            <= 1'b0;
      score_l_r          <= 4'd0;
      score_r_r          <= 4'd0;
      game_over_r        <= 1'b0;
    end else begin
      state_r            <= state_s;
      serve_cnt_r        <= serve_cnt_s;
      paddle_collision_r <= paddle_collision_s;
      ball_collision_r   <= ball_collision_s;
      hit_offset_r       <= hit_offset_s;
      serve_r            <= serve_s;
      score_l_r          <= score_l_s;
      score_r_r          <= score_r_s;
      game_over_r        <= game_over_s;
    end
  end

  assign paddle_collision = paddle_collision_r;
  assign ball_collision   = ball_collision_r;
  assign hit_offset       = hit_offset_r;
  assign serve            = serve_r;
  assign score_l          = score_l_r;
  assign score_r          = score_r_r;
  assign game_over        = game_over_r;

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: stimulus pushes the expected
// registered response for each frame tick / reset cycle, a monitor pops and
// compares on the following falling edge and checks pulses stay low otherwise.
module tb_collision_detector;

  typedef struct packed {
    logic       pc;
    logic       bc;
    logic       sv;
    logic [2:0] off;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [5:0] bx, by, lpad_y, rpad_y;
  logic       bx_dir, by_dir;
  logic       paddle_collision, ball_collision, serve, game_over;
  logic [2:0] hit_offset;
  logic [3:0] score_l, score_r;

  exp_t sb_q[$];
  logic resp_due = 1'b0;
  logic armed    = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   resp_idx = 0;

  logic       e_go  = 1'b0;
  logic [2:0] e_off = 3'd0;
  logic [3:0] e_sl  = 4'd0;
  logic [3:0] e_sr  = 4'd0;

  always #5 clk = ~clk;

  collision_detector #(
    .PAD_H(8), .COOLDOWN(2), .SERVE_DELAY(30), .WIN_SCORE(9)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_tick       (frame_tick),
    .bx               (bx),
    .by               (by),
    .bx_dir           (bx_dir),
    .by_dir           (by_dir),
    .lpad_y           (lpad_y),
    .rpad_y           (rpad_y),
    .paddle_collision (paddle_collision),
    .ball_collision   (ball_collision),
    .hit_offset       (hit_offset),
    .serve            (serve),
    .score_l          (score_l),
    .score_r          (score_r),
    .game_over        (game_over)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (resp %0d): got %0d expected %0d", name, resp_idx, act, exp);
    end
  endtask

  // A response is due on the cycle after a sampled frame tick or reset.
  always @(posedge clk) resp_due <= frame_tick || !reset;

  // Monitor: compare the registered outputs against the scoreboard.
  always @(negedge clk) begin
    if (resp_due) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_underflow", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("paddle_collision", {7'd0, paddle_collision}, {7'd0, e.pc});
        chk("ball_collision",   {7'd0, ball_collision},   {7'd0, e.bc});
        chk("serve",            {7'd0, serve},            {7'd0, e.sv});
        chk("hit_offset",       {5'd0, hit_offset},       {5'd0, e.off});
        chk("score_l",          {4'd0, score_l},          {4'd0, e.sl});
        chk("score_r",          {4'd0, score_r},          {4'd0, e.sr});
        chk("game_over",        {7'd0, game_over},        {7'd0, e.go});
        resp_idx++;
      end
    end else if (armed) begin
      chk("idle_pulses", {5'd0, paddle_collision, ball_collision, serve}, 8'd0);
    end
  end

  task automatic push_exp(input logic pc, input logic bc, input logic sv);
    exp_t e;
    e.pc  = pc;
    e.bc  = bc;
    e.sv  = sv;
    e.off = e_off;
    e.sl  = e_sl;
    e.sr  = e_sr;
    e.go  = e_go;
    sb_q.push_back(e);
  endtask

  task automatic tick(input logic [5:0] x, input logic [5:0] y, input logic xd,
                      input logic yd, input logic [5:0] lp, input logic [5:0] rp,
                      input logic pc, input logic bc, input logic sv);
    @(posedge clk); #2;
    bx = x; by = y; bx_dir = xd; by_dir = yd; lpad_y = lp; rpad_y = rp;
    frame_tick = 1'b1;
    push_exp(pc, bc, sv);
    @(posedge clk); #2;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic neutral();
    tick(6'd30, 6'd30, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Ball placed on a would-be paddle+wall strike: nothing may fire outside PLAY.
  task automatic hostile(input logic sv);
    tick(6'd2, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, sv);
  endtask

  task automatic serve_wait();
    for (int i = 1; i <= 30; i++) hostile(i == 30);
  endtask

  task automatic do_reset();
    e_sl = 4'd0; e_sr = 4'd0; e_go = 1'b0; e_off = 3'd0;
    @(posedge clk); #2;
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  // Reset asserted on the same cycle as a frame tick that would serve.
  task automatic reset_tick();
    e_sl = 4'd0; e_sr = 4'd0; e_go = 1'b0; e_off = 3'd0;
    @(posedge clk); #2;
    reset = 1'b0;
    frame_tick = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    bx = 6'd30; by = 6'd30; bx_dir = 1'b1; by_dir = 1'b1; lpad_y = 6'd0; rpad_y = 6'd0;

    do_reset();
    armed = 1'b1;

    // Serve fires on the 30th tick only.
    serve_wait();

    // Left paddle hit, offset 20-16=4, then two suppressed ticks, then fires again.
    e_off = 3'd4;
    tick(6'd2, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b1, 1'b0, 1'b0);
    tick(6'd2, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b0, 1'b0, 1'b0);
    tick(6'd2, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b0, 1'b0, 1'b0);
    tick(6'd2, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b1, 1'b0, 1'b0);
    neutral(); neutral();

    // Top wall, suppressed repeat, bottom wall after cooldown expires.
    tick(6'd30, 6'd0,  1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick(6'd30, 6'd0,  1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    neutral();
    tick(6'd30, 6'd63, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    neutral(); neutral();

    // Corner: right paddle and bottom wall together, offset 63-56=7.
    e_off = 3'd7;
    tick(6'd62, 6'd63, 1'b1, 1'b1, 6'd0, 6'd56, 1'b1, 1'b1, 1'b0);
    neutral(); neutral();

    // Paddle at 60 does not wrap to cover row 2; ball then reaches x=0.
    tick(6'd1, 6'd2, 1'b0, 1'b1, 6'd60, 6'd0, 1'b0, 1'b0, 1'b0);
    e_sr = 4'd1;
    tick(6'd0, 6'd2, 1'b0, 1'b1, 6'd60, 6'd0, 1'b0, 1'b0, 1'b0);
    serve_wait();

    // Plain left miss scores right.
    e_sr = 4'd2;
    tick(6'd0, 6'd40, 1'b0, 1'b1, 6'd16, 6'd0, 1'b0, 1'b0, 1'b0);
    serve_wait();

    // Overlap at the goal column is a paddle hit, not a goal (both sides).
    e_off = 3'd4;
    tick(6'd0, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b1, 1'b0, 1'b0);
    neutral(); neutral();
    e_off = 3'd2;
    tick(6'd63, 6'd10, 1'b1, 1'b1, 6'd0, 6'd8, 1'b1, 1'b0, 1'b0);
    neutral(); neutral();

    // Left player scores nine times; the ninth ends the game.
    for (int k = 1; k <= 9; k++) begin
      e_sl = 4'(k);
      tick(6'd63, 6'd40, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      if (k < 9) serve_wait();
    end

    // Game over: no pulses, no serve, scores frozen.
    e_go = 1'b1;
    tick(6'd63, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick(6'd2, 6'd20, 1'b0, 1'b1, 6'd16, 6'd0, 1'b0, 1'b0, 1'b0);
    tick(6'd0, 6'd40, 1'b0, 1'b1, 6'd16, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) hostile(1'b0);

    // Reset from OVER clears everything.
    do_reset();

    // Reset coinciding with the serving tick cancels it and reloads the delay.
    for (int i = 0; i < 29; i++) hostile(1'b0);
    reset_tick();
    serve_wait();

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
